// File: rtl/pixel_framebuffer_scanout_pkg.sv
// rtl/pixel_framebuffer_scanout_pkg.sv - shared timing defaults, colour-bit indices and types for the scanout
package pixel_framebuffer_scanout_pkg;
  localparam int DEF_COLOUR_BITS = 3;
  localparam int DEF_FB_W        = 160;
  localparam int DEF_FB_H        = 120;
  localparam int DEF_SCALE_SHIFT = 2;
  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_H_FP        = 16;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BP        = 48;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_V_FP        = 10;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BP        = 33;

  localparam int CNT_W = 10;
  localparam int CH_W  = 10;
  localparam int R_BIT = 2;
  localparam int G_BIT = 1;
  localparam int B_BIT = 0;

  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } vga_ctrl_t;

  localparam vga_ctrl_t CTRL_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0};

  function automatic logic [CH_W-1:0] expand_channel(input logic b);
    return {CH_W{b}};
  endfunction
endpackage

// File: rtl/pixel_framebuffer_scanout_timing.sv
// rtl/pixel_framebuffer_scanout_timing.sv - pixel tick, h/v counters, raw sync/active and frame pulse
module pixel_framebuffer_scanout_timing
  import pixel_framebuffer_scanout_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clock,
  input  logic             reset,
  output logic             pix_en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output vga_ctrl_t        ctrl,
  output logic             frame
);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_PRE    = CNT_W'(V_ACTIVE - 1);

  logic h_wrap;
  assign h_wrap = (hcount == H_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_en <= 1'b0;
      hcount <= '0;
      vcount <= '0;
      frame  <= 1'b0;
    end else begin
      pix_en <= ~pix_en;
      // High for the clock right after vcount steps onto the first blank line
      frame  <= pix_en && h_wrap && (vcount == V_PRE);
      if (pix_en) begin
        if (h_wrap) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end else begin
          hcount <= hcount + 1'b1;
        end
      end
    end
  end

  always_comb begin
    ctrl        = CTRL_IDLE;
    ctrl.hs     = !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
    ctrl.vs     = !((vcount >= VS_FIRST) && (vcount <= VS_LAST));
    ctrl.active = (hcount < H_ACT) && (vcount < V_ACT);
  end
endmodule

// File: rtl/pixel_framebuffer_scanout.sv
// rtl/pixel_framebuffer_scanout.sv - 160x120 framebuffer written by a pixel stream, scanned out as 4x-replicated VGA
module pixel_framebuffer_scanout
  import pixel_framebuffer_scanout_pkg::*;
#(
  parameter int COLOUR_BITS = DEF_COLOUR_BITS,
  parameter int FB_W        = DEF_FB_W,
  parameter int FB_H        = DEF_FB_H,
  parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             x,
  input  logic [6:0]             y,
  input  logic [COLOUR_BITS-1:0] colour,
  input  logic                   plot,
  output logic                   frame,
  output logic                   VGA_CLK,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_BLANK_N,
  output logic                   VGA_SYNC_N,
  output logic [CH_W-1:0]        VGA_R,
  output logic [CH_W-1:0]        VGA_G,
  output logic [CH_W-1:0]        VGA_B
);
  localparam int FB_SIZE = FB_W * FB_H;
  localparam int ADDR_W  = $clog2(FB_SIZE);

  logic                   pix_en;
  logic [CNT_W-1:0]       hcount;
  logic [CNT_W-1:0]       vcount;
  vga_ctrl_t              ctrl_raw;
  vga_ctrl_t              ctrl_d1;
  vga_ctrl_t              ctrl_d2;
  logic [ADDR_W-1:0]      pix_index;
  logic [ADDR_W-1:0]      rd_addr;
  logic [COLOUR_BITS-1:0] rd_data;
  logic [ADDR_W-1:0]      wr_index;
  logic                   wr_en;
  logic [COLOUR_BITS-1:0] mem [FB_SIZE];

  pixel_framebuffer_scanout_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clock  (clock),
    .reset  (reset),
    .pix_en (pix_en),
    .hcount (hcount),
    .vcount (vcount),
    .ctrl   (ctrl_raw),
    .frame  (frame)
  );

  // Constant multiply by FB_W reduces to (r<<7)+(r<<5) at the 160-wide default
  assign pix_index = ADDR_W'((32'(vcount) >> SCALE_SHIFT) * FB_W + (32'(hcount) >> SCALE_SHIFT));
  assign wr_index  = ADDR_W'(32'(y) * FB_W + 32'(x));
  assign wr_en     = plot && (32'(x) < FB_W) && (32'(y) < FB_H);

  always_ff @(posedge clock) begin
    if (!reset && wr_en) begin
      mem[wr_index] <= colour;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_addr <= '0;
      rd_data <= '0;
      ctrl_d1 <= CTRL_IDLE;
      ctrl_d2 <= CTRL_IDLE;
    end else if (pix_en) begin
      rd_addr <= ctrl_raw.active ? pix_index : '0;
      ctrl_d1 <= ctrl_raw;
      rd_data <= mem[rd_addr];
      ctrl_d2 <= ctrl_d1;
    end
  end

  assign VGA_CLK     = pix_en;
  assign VGA_HS      = ctrl_d2.hs;
  assign VGA_VS      = ctrl_d2.vs;
  assign VGA_BLANK_N = ctrl_d2.active;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = expand_channel(ctrl_d2.active & rd_data[R_BIT]);
  assign VGA_G       = expand_channel(ctrl_d2.active & rd_data[G_BIT]);
  assign VGA_B       = expand_channel(ctrl_d2.active & rd_data[B_BIT]);
endmodule

// File: tb/tb_pixel_framebuffer_scanout.sv
// tb/tb_pixel_framebuffer_scanout.sv - randomized scanout bench against a position-based framebuffer model
module tb_pixel_framebuffer_scanout;
  localparam int FB_W  = 16;
  localparam int FB_H  = 8;
  localparam int SS    = 2;
  localparam int SCALE = 4;
  localparam int HA = 64, HF = 4, HSY = 8, HB = 4;
  localparam int VA = 32, VF = 2, VSY = 2, VB = 4;
  localparam int H_T = HA + HF + HSY + HB;
  localparam int V_T = VA + VF + VSY + VB;
  localparam int FRAME_T = H_T * V_T;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       plot = 1'b0;
  logic [7:0] x = 8'd0;
  logic [6:0] y = 7'd0;
  logic [2:0] colour = 3'd0;
  logic       frame, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [9:0] VGA_R, VGA_G, VGA_B;

  always #5 clock = ~clock;

  pixel_framebuffer_scanout #(
    .COLOUR_BITS(3), .FB_W(FB_W), .FB_H(FB_H), .SCALE_SHIFT(SS),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut (
    .clock(clock), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
    .frame(frame), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  int         checks = 0;
  int         errors = 0;
  int         k = 0;
  int         hs_fall_k = -1;
  logic       prev_hs = 1'b1;
  logic [2:0] fb [FB_W*FB_H];
  logic [2:0] exp_col = 3'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic compare_all(input logic eclk, input logic ehs, input logic evs,
                             input logic eact, input logic [2:0] ecol, input logic efr);
    logic [9:0] er, eg, eb;
    er = (eact && ecol[2]) ? 10'h3FF : 10'h000;
    eg = (eact && ecol[1]) ? 10'h3FF : 10'h000;
    eb = (eact && ecol[0]) ? 10'h3FF : 10'h000;
    check("vga_clk", 32'(VGA_CLK), 32'(eclk));
    check("hs", 32'(VGA_HS), 32'(ehs));
    check("vs", 32'(VGA_VS), 32'(evs));
    check("blank_n", 32'(VGA_BLANK_N), 32'(eact));
    check("sync_n", 32'(VGA_SYNC_N), 32'd0);
    check("red", 32'(VGA_R), 32'(er));
    check("green", 32'(VGA_G), 32'(eg));
    check("blue", 32'(VGA_B), 32'(eb));
    check("frame", 32'(frame), 32'(efr));
  endtask

  // One clock: inputs go out now, the edge happens, outputs are judged at the following negedge
  task automatic step(input logic p, input logic [7:0] xi, input logic [6:0] yi, input logic [2:0] ci);
    int   pos, q, h, v;
    logic ehs, evs, eact, efr;
    plot = p; x = xi; y = yi; colour = ci;
    @(negedge clock);
    if (reset) begin
      k = 0;
      hs_fall_k = -1;
      prev_hs = 1'b1;
      compare_all(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    end else begin
      k++;
      pos = k / 2 - 2;
      ehs = 1'b1; evs = 1'b1; eact = 1'b0;
      if (pos >= 0) begin
        q = pos % FRAME_T;
        h = q % H_T;
        v = q / H_T;
        ehs  = !(h >= HA + HF && h < HA + HF + HSY);
        evs  = !(v >= VA + VF && v < VA + VF + VSY);
        eact = (h < HA) && (v < VA);
        if (k % 2 == 0 && eact) exp_col = fb[(v / SCALE) * FB_W + h / SCALE];
      end
      efr = (k % 2 == 0) && ((k / 2) % FRAME_T == VA * H_T);
      compare_all(1'(k % 2), ehs, evs, eact, exp_col, efr);
      if (prev_hs && !VGA_HS && hs_fall_k < 0) hs_fall_k = k;
      prev_hs = VGA_HS;
      if (p && int'(xi) < FB_W && int'(yi) < FB_H) fb[int'(yi) * FB_W + int'(xi)] = ci;
    end
  endtask

  initial begin
    int fcnt, vcnt;
    for (int i = 0; i < FB_W * FB_H; i++) fb[i] = 3'd0;

    #2 reset = 1'b1;
    #1 compare_all(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    repeat (3) step(1'b1, 8'd1, 7'd1, 3'd7);
    reset = 1'b0;

    fcnt = 0;
    vcnt = 0;
    for (int i = 0; i < 2 * FRAME_T + 200; i++) begin
      step(1'b0, 8'd0, 7'd0, 3'd0);
      if (frame) fcnt++;
      if (!VGA_VS) vcnt++;
    end
    check("hs_first_fall", 32'(hs_fall_k), 32'(2 * (HA + HF) + 4));
    check("frame_pulses", 32'(fcnt), 32'd1);
    check("vs_low_clocks", 32'(vcnt), 32'(2 * VSY * H_T));

    step(1'b1, 8'd0, 7'd0, 3'b011);
    step(1'b1, 8'(FB_W - 1), 7'(FB_H - 1), 3'b100);
    step(1'b1, 8'(FB_W), 7'd1, 3'b111);
    step(1'b1, 8'd0, 7'(FB_H), 3'b101);
    step(1'b1, 8'(FB_W - 1), 7'd0, 3'b110);
    repeat (2 * FRAME_T) step(1'b0, 8'd0, 7'd0, 3'd0);

    for (int i = 0; i < 4 * FRAME_T; i++)
      step($urandom_range(3, 0) == 0, 8'($urandom_range(FB_W + 3, 0)),
           7'($urandom_range(FB_H + 2, 0)), 3'($urandom));

    for (int i = 0; i < 2 * FRAME_T; i++)
      step(1'b1, 8'd5, 7'd3, (i % 2 == 1) ? 3'b010 : 3'b101);

    for (int i = 0; i < 2 * FRAME_T && ((k / 2) % FRAME_T != 15 * H_T + 30); i++)
      step(1'b0, 8'd0, 7'd0, 3'd0);
    #2 reset = 1'b1;
    #1 compare_all(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    repeat (4) step(1'b1, 8'd2, 7'd2, 3'b110);
    reset = 1'b0;
    for (int i = 0; i < 2 * FRAME_T + 200; i++) step(1'b0, 8'd0, 7'd0, 3'd0);
    check("hs_fall_after_reset", 32'(hs_fall_k), 32'(2 * (HA + HF) + 4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
